// File: rtl/matrix_result_writer_pkg.sv
// Shared definitions for the 4x4 matrix multiplier and its result writer.
// Both sides import this package so they agree on the element packing of the
// result bus and on the writer's state encoding.
package matrix_result_writer_pkg;

  // Matrix dimension; N*N elements per job
  localparam int N         = 4;
  // Width of one result element on the packed bus
  localparam int ELEM_W    = 16;
  // Width of the running checksum
  localparam int R_WIDTH   = 32;
  // Physical width of the packed result bus from the multiplier
  localparam int BUS_W     = 512;
  // Derived element count and the number of bus bits that carry elements
  localparam int NUM_ELEMS = N * N;
  localparam int CAP_W     = NUM_ELEMS * ELEM_W;

  // Writer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } wr_state_t;

  // Zero-extend one result element to checksum width
  function automatic logic [R_WIDTH-1:0] elem_to_sum(input logic [ELEM_W-1:0] elem);
    return R_WIDTH'(elem);
  endfunction

endpackage

// File: rtl/matrix_result_writer.sv
// Result writer for the 4x4 matrix multiplier.
// Captures the packed result on the multiplier's Done pulse, then streams the
// elements to result memory one word per accepted valid/ready handshake while
// accumulating a 32-bit checksum. The multiplier is free again as soon as the
// capture cycle has passed; a Done that arrives while a job is in flight is
// discarded and reported on Drop.
module matrix_result_writer
  import matrix_result_writer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Done,
  input  logic [BUS_W-1:0]   MULT_OUT,
  input  logic [ADDR_W-1:0]  Base_Addr,
  output logic               Mem_WE,
  output logic [ADDR_W-1:0]  Mem_Addr,
  output logic [DATA_W-1:0]  Mem_WData,
  input  logic               Mem_Ready,
  output logic               Busy,
  output logic               WB_Done,
  output logic [R_WIDTH-1:0] Checksum,
  output logic               Drop
);

  localparam int IDX_W = $clog2(NUM_ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  wr_state_t           state;
  logic [CAP_W-1:0]    cap_buf;
  logic [ADDR_W-1:0]   base_addr;
  logic [IDX_W-1:0]    idx;

  logic [IDX_W-1:0]    next_idx;
  logic [ELEM_W-1:0]   cur_elem;
  logic [ELEM_W-1:0]   next_elem;
  logic [ADDR_W-1:0]   next_addr;

  // Bus bits above the packed elements carry nothing for this writer
  if (CAP_W < BUS_W) begin : g_unused_upper
    logic unused_upper;
    assign unused_upper = ^MULT_OUT[BUS_W-1:CAP_W];
  end

  // Element currently on the write port and the one that follows it; the next
  // address is rebuilt from the sampled base so it always equals base+idx*stride
  always_comb begin
    next_idx  = idx + IDX_W'(1);
    cur_elem  = cap_buf[ELEM_W*idx +: ELEM_W];
    next_elem = cap_buf[ELEM_W*next_idx +: ELEM_W];
    next_addr = base_addr + ADDR_W'(int'(next_idx) * ADDR_STRIDE);
  end

  // Writer FSM: capture, stream with handshake, then a one-cycle completion pulse
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cap_buf   <= '0;
      base_addr <= '0;
      idx       <= '0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      Busy      <= 1'b0;
      WB_Done   <= 1'b0;
      Checksum  <= '0;
      Drop      <= 1'b0;
    end else begin
      WB_Done <= 1'b0;
      Drop    <= 1'b0;
      case (state)
        IDLE: begin
          if (Done) begin
            cap_buf   <= MULT_OUT[CAP_W-1:0];
            base_addr <= Base_Addr;
            idx       <= '0;
            Checksum  <= '0;
            Busy      <= 1'b1;
            Mem_WE    <= 1'b1;
            Mem_Addr  <= Base_Addr;
            Mem_WData <= DATA_W'(MULT_OUT[ELEM_W-1:0]);
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (Done) begin
            Drop <= 1'b1;
          end
          if (Mem_Ready) begin
            Checksum <= Checksum + elem_to_sum(cur_elem);
            if (idx == LAST_IDX) begin
              Mem_WE  <= 1'b0;
              WB_Done <= 1'b1;
              state   <= FINISH;
            end else begin
              idx       <= next_idx;
              Mem_Addr  <= next_addr;
              Mem_WData <= DATA_W'(next_elem);
            end
          end
        end
        FINISH: begin
          if (Done) begin
            Drop <= 1'b1;
          end
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Mem_WE <= 1'b0;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_writer.sv
// Self-checking bench for matrix_result_writer.
// A table of job descriptions is played through a reference model that works
// from the job's elements, base address and memory-ready pattern alone.
module tb_matrix_result_writer;
  import matrix_result_writer_pkg::*;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Done;
  logic [511:0]  MULT_OUT;
  logic [15:0]   Base_Addr;
  logic          Mem_WE;
  logic [15:0]   Mem_Addr;
  logic [31:0]   Mem_WData;
  logic          Mem_Ready;
  logic          Busy;
  logic          WB_Done;
  logic [31:0]   Checksum;
  logic          Drop;

  int tests = 0;
  int fails = 0;

  // fill: 0 = element e holds e+1, 1 = all 0xFFFF with upper bus bits set, 2 = random
  // rmode: 0 = ready always, 1 = ready low on every other cycle, 2 = random
  typedef struct {
    logic [15:0] base;
    int          fill;
    int          rmode;
    int          done2;
    logic [31:0] exp_sum;
    int          exp_lat;
    bit          chk_const;
  } vec_t;

  vec_t vecs[$];

  matrix_result_writer #(
    .DATA_W(32),
    .ADDR_W(16),
    .ADDR_STRIDE(1)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Done(Done),
    .MULT_OUT(MULT_OUT),
    .Base_Addr(Base_Addr),
    .Mem_WE(Mem_WE),
    .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData),
    .Mem_Ready(Mem_Ready),
    .Busy(Busy),
    .WB_Done(WB_Done),
    .Checksum(Checksum),
    .Drop(Drop)
  );

  // Free-running clock, 10 time units per cycle
  always #5 Clk = ~Clk;

  // Global time limit so a stuck design still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [511:0] rand_bus();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // Play one job and compare every cycle against the reference model
  task automatic applyStimulus(input vec_t v);
    logic [15:0]  elems[16];
    logic [15:0]  exp_addr[16];
    logic [31:0]  exp_data[16];
    logic [31:0]  model_sum;
    logic [511:0] mo;
    bit           rdy[256];
    int           model_wb;
    int           acc;
    int           k;
    int           act_wb;

    mo = (v.fill == 1) ? '1 : ((v.fill == 2) ? rand_bus() : '0);
    model_sum = 0;
    for (int e = 0; e < 16; e++) begin
      case (v.fill)
        0:       elems[e] = 16'(e + 1);
        1:       elems[e] = 16'hFFFF;
        default: elems[e] = 16'($urandom);
      endcase
      mo[16*e +: 16] = elems[e];
      exp_addr[e]    = v.base + 16'(e);
      exp_data[e]    = {16'h0000, elems[e]};
      model_sum      = model_sum + {16'h0000, elems[e]};
    end

    for (int c = 0; c < 256; c++) begin
      case (v.rmode)
        0:       rdy[c] = 1'b1;
        1:       rdy[c] = (c % 2 == 0);
        default: rdy[c] = (c >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
      endcase
    end

    // WB_Done is expected the cycle after the 16th ready cycle counted from t+1
    acc = 0;
    model_wb = 0;
    for (int c = 1; c < 256 && model_wb == 0; c++) begin
      if (rdy[c]) begin
        acc++;
        if (acc == 16) model_wb = c + 1;
      end
    end

    Done      = 1'b1;
    MULT_OUT  = mo;
    Base_Addr = v.base;
    Mem_Ready = 1'b0;
    tick();
    Done      = 1'b0;
    MULT_OUT  = rand_bus();
    Base_Addr = 16'($urandom);

    k = 0;
    act_wb = 0;
    for (int c = 1; c <= model_wb + 1; c++) begin
      Mem_Ready = rdy[c];
      Done = (v.done2 != 0 && c == v.done2);
      if (Done) MULT_OUT = rand_bus();
      checkOutput("drop", {31'b0, Drop}, {31'b0, (v.done2 != 0 && c == v.done2 + 1)});
      if (WB_Done && act_wb == 0) act_wb = c;
      if (c < model_wb) begin
        checkOutput("mem_we", {31'b0, Mem_WE}, 32'd1);
        checkOutput("busy", {31'b0, Busy}, 32'd1);
        checkOutput("wb_done_early", {31'b0, WB_Done}, 32'd0);
        checkOutput("mem_addr", {16'h0, Mem_Addr}, {16'h0, exp_addr[k]});
        checkOutput("mem_wdata", Mem_WData, exp_data[k]);
        if (rdy[c]) k++;
      end else if (c == model_wb) begin
        checkOutput("mem_we_finish", {31'b0, Mem_WE}, 32'd0);
        checkOutput("checksum", Checksum, v.chk_const ? v.exp_sum : model_sum);
      end else begin
        checkOutput("busy_after", {31'b0, Busy}, 32'd0);
        checkOutput("wb_done_after", {31'b0, WB_Done}, 32'd0);
        checkOutput("mem_we_idle", {31'b0, Mem_WE}, 32'd0);
        checkOutput("checksum_hold", Checksum, model_sum);
      end
      tick();
    end
    Done = 1'b0;
    checkOutput("wb_latency", act_wb, v.chk_const ? v.exp_lat : model_wb);
  endtask

  initial begin
    int wb_seen;
    vec_t v;

    vecs.push_back('{16'h0100, 0, 0, 0, 32'd136,        17, 1'b1});
    vecs.push_back('{16'h0100, 0, 1, 0, 32'd136,        33, 1'b1});
    vecs.push_back('{16'hFFFE, 0, 0, 0, 32'd136,        17, 1'b1});
    vecs.push_back('{16'h2000, 1, 0, 0, 32'h000FFFF0,   17, 1'b1});
    vecs.push_back('{16'h0100, 0, 0, 5, 32'd136,        17, 1'b1});
    for (int i = 0; i < 6; i++) begin
      v.base      = 16'($urandom);
      v.fill      = 2;
      v.rmode     = 2;
      v.done2     = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 12)) : 0;
      v.exp_sum   = 32'd0;
      v.exp_lat   = 0;
      v.chk_const = 1'b0;
      vecs.push_back(v);
    end

    Rst       = 1'b1;
    Done      = 1'b0;
    MULT_OUT  = '0;
    Base_Addr = '0;
    Mem_Ready = 1'b0;
    #12;
    checkOutput("reset_mem_we", {31'b0, Mem_WE}, 32'd0);
    checkOutput("reset_busy", {31'b0, Busy}, 32'd0);
    checkOutput("reset_wb_done", {31'b0, WB_Done}, 32'd0);
    checkOutput("reset_drop", {31'b0, Drop}, 32'd0);
    checkOutput("reset_checksum", Checksum, 32'd0);
    checkOutput("reset_addr", {16'h0, Mem_Addr}, 32'd0);
    checkOutput("reset_wdata", Mem_WData, 32'd0);
    Rst = 1'b0;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Abandon a job with an asynchronous reset after the 7th accepted write
    for (int e = 0; e < 16; e++) MULT_OUT[16*e +: 16] = 16'(e + 1);
    Done      = 1'b1;
    Base_Addr = 16'h0100;
    Mem_Ready = 1'b1;
    tick();
    Done = 1'b0;
    for (int c = 1; c <= 7; c++) tick();
    checkOutput("pre_reset_checksum", Checksum, 32'd28);
    checkOutput("pre_reset_addr", {16'h0, Mem_Addr}, 32'h0107);
    #1 Rst = 1'b1;
    #1;
    checkOutput("async_reset_mem_we", {31'b0, Mem_WE}, 32'd0);
    checkOutput("async_reset_busy", {31'b0, Busy}, 32'd0);
    checkOutput("async_reset_wb_done", {31'b0, WB_Done}, 32'd0);
    checkOutput("async_reset_checksum", Checksum, 32'd0);
    #1 Rst = 1'b0;
    wb_seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (WB_Done || Mem_WE) wb_seen++;
    end
    checkOutput("no_activity_after_reset", wb_seen, 32'd0);
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
